instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Instruction fetch and issue stage that drives the 6-bit opcode consumed by the main control decoder. It sequences the PC and runs a request/ready handshake with instruction memory. It holds the fetched word in an instruction register until the downstream stage accepts it, and redirects on taken branches and jumps (beq, brnv, bgtzal, balv, jmnor, jrsal) resolved by the datapath.

## Interface
- PC_W, 32, PC and memory address width
- RESET_PC, 32'h0000_0000, first fetch address after reset

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request; held until accepted
- imem_addr  out  PC_W  fetch address; stable while imem_req=1
- imem_ready  in  1  memory accepts request and returns imem_rdata in the same cycle
- imem_rdata  in  32  instruction word
- instr  out  32  instruction register
- opcode  out  6  instr[31:26], to control decoder `in`
- instr_valid  out  1  instr/opcode/link_pc valid
- stall  in  1  downstream not accepting; hold instr
- jump_en  in  1  jump redirect (jmnor, jrsal)
- jump_target  in  PC_W  jump destination
- branch_taken  in  1  branch redirect (beq, brnv, bgtzal, balv, already qualified)
- branch_target  in  PC_W  branch destination
- link_pc  out  PC_W  address of instr + 4, for linking instructions
- align_err  out  1  one-cycle pulse on rejected misaligned target (macro only)

## Operation
- States: BOOT, FETCH, ISSUE, DRAIN.
- BOOT: reset state, outputs idle; go to FETCH unconditionally on the first clk after reset deasserts.
- FETCH: imem_req=1, imem_addr=pc.
  - On imem_ready: instr<=imem_rdata, link_pc<=pc+4, go to ISSUE.
- ISSUE: instr_valid=1.
  - If !stall: pc<=pc+4, go to FETCH.
  - If stall: hold everything.
- Redirect: target = jump_target if jump_en, else branch_target. jump_en has priority when both are asserted.
  - In ISSUE or BOOT: pc<=target, instr_valid drops next cycle, go to FETCH. Stall is ignored.
  - In FETCH with imem_ready=1 the same cycle: discard imem_rdata, pc<=target, stay in FETCH.
  - In FETCH with imem_ready=0: latch target into pend_pc, go to DRAIN. The current request must complete with its address unchanged.
- DRAIN: imem_req=1 with the old address.
  - A new redirect overwrites pend_pc; the latest redirect wins.
  - On imem_ready: discard data, pc<=pend_pc, go to FETCH.
- PC arithmetic: modulo 2^PC_W; pc+4 wraps silently from all-ones region to 0.

## Timing
- Reset values: pc=RESET_PC, instr=0, opcode=0, instr_valid=0, imem_req=0, imem_addr=RESET_PC, link_pc=0, align_err=0, pend_pc=0, state=BOOT.
- Reset asserted mid-handshake aborts immediately. No completion of the outstanding request is owed.
- Zero-wait memory:
  - imem_ready in FETCH cycle N gives instr_valid=1 in cycle N+1.
  - With no stall, FETCH is re-entered in N+2.
  - Throughput: one instruction per 2 cycles.
- Redirect in cycle N (ISSUE) gives imem_addr=target in cycle N+1.
- Redirect in FETCH without ready, memory ready at cycle M, gives imem_addr=target in cycle M+1.
- opcode is combinationally instr[31:26]. All other outputs are registered or decoded from state only. No combinational path from any input to any output.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - A redirect target with target[1:0]!=0 is rejected and align_err pulses for one cycle.
  - The redirect is ignored: pc and state proceed as if no redirect occurred.
- FETCH_ALIGN_CHECK_EN undefined:
  - target[1:0] is forced to 2'b00 and the redirect is taken.
  - align_err is tied to 0.

## Test plan
- Reset release, RESET_PC=0, imem_ready=1 always:
  - imem_addr sequence 0,4,8.
  - instr_valid high every 2nd cycle.
  - opcode=6'h23 when rdata=32'h8C00_0000.
- stall=1 for 3 cycles in ISSUE:
  - instr, link_pc and instr_valid held constant.
  - imem_req=0 throughout.
  - Fetch of pc+4 follows on the cycle after stall drops.
- branch_taken=1, target=0x40, asserted in ISSUE together with stall=1: next imem_addr=0x40 and instr_valid=0.
- Redirect to 0x80 while imem_ready=0, ready arriving 2 cycles later:
  - imem_addr stays at the old address until ready.
  - The data is discarded and never raises instr_valid.
  - imem_addr=0x80 on the following cycle.
- jump_en and branch_taken asserted together (0x100 vs 0x200): fetch goes to 0x100.
- Target 0x42:
  - With macro: align_err pulses and sequential fetch continues.
  - Without macro: fetch goes to 0x40.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Instruction fetch/issue stage. Sequences the PC, runs a req/ready
//   handshake with instruction memory, holds the fetched word until the
//   downstream stage accepts it, and applies jump/branch redirects.
//
//   Ports:
//     clk, reset                     rising-edge clock, async active-high reset
//     imem_req/imem_addr             fetch request and address (held until ready)
//     imem_ready/imem_rdata          accept strobe and same-cycle instruction word
//     instr/opcode/instr_valid       instruction register, instr[31:26], valid flag
//     link_pc                        address of instr + 4
//     stall                          downstream hold while instr_valid
//     jump_en/jump_target            jump redirect (priority over branch)
//     branch_taken/branch_target     qualified branch redirect
//     align_err                      one-cycle pulse on rejected misaligned target
//
//   Build option: FETCH_ALIGN_CHECK_EN
//     defined   -> misaligned redirect targets are ignored and align_err pulses
//     undefined -> target[1:0] is forced to 0, align_err tied low
module instr_fetch_unit #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic [5:0]      opcode,
  output logic            instr_valid,
  input  logic            stall,
  input  logic            jump_en,
  input  logic [PC_W-1:0] jump_target,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic [PC_W-1:0] link_pc,
  output logic            align_err
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [PC_W-1:0] link_pc_q, link_pc_d;
  logic [PC_W-1:0] pend_pc_q, pend_pc_d;

  logic            redir_req;
  logic [PC_W-1:0] redir_raw;
  logic            redir;
  logic [PC_W-1:0] redir_target;

  assign redir_req = jump_en | branch_taken;
  assign redir_raw = jump_en ? jump_target : branch_target;

`ifdef FETCH_ALIGN_CHECK_EN
  logic align_err_q, align_err_d;

  always_comb begin
    redir        = redir_req & ~(|redir_raw[1:0]);
    redir_target = redir_raw;
    align_err_d  = redir_req & (|redir_raw[1:0]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) align_err_q <= 1'b0;
    else       align_err_q <= align_err_d;
  end

  assign align_err = align_err_q;
`else
  always_comb begin
    redir        = redir_req;
    redir_target = redir_raw & ~PC_W'(3);
  end

  assign align_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    link_pc_d = link_pc_q;
    pend_pc_d = pend_pc_q;
    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
        if (redir) pc_d = redir_target;
      end
      FETCH: begin
        if (redir) begin
          // pc must stay on the outstanding address until memory accepts it,
          // so an unaccepted redirect is parked in pend_pc.
          if (imem_ready) begin
            pc_d = redir_target;
          end else begin
            pend_pc_d = redir_target;
            state_d   = DRAIN;
          end
        end else if (imem_ready) begin
          instr_d   = imem_rdata;
          link_pc_d = pc_q + PC_W'(4);
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (redir) begin
          pc_d    = redir_target;
          state_d = FETCH;
        end else if (!stall) begin
          pc_d    = pc_q + PC_W'(4);
          state_d = FETCH;
        end
      end
      DRAIN: begin
        // A redirect arriving together with ready is the latest one and wins.
        if (redir) pend_pc_d = redir_target;
        if (imem_ready) begin
          pc_d    = redir ? redir_target : pend_pc_q;
          state_d = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      link_pc_q <= '0;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      link_pc_q <= link_pc_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  assign imem_req    = (state_q == FETCH) || (state_q == DRAIN);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign instr_valid = (state_q == ISSUE);
  assign link_pc     = link_pc_q;

endmodule
